// File: rtl/eth_pkg.sv
// Shared Ethernet/IP/UDP types used by the UDP transmit path.
// IPInfo carries per-packet addressing handed to the transmitter;
// IPHeader and UDPHeader describe the wire headers built from it.
package eth_pkg;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } IPInfo;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  tos;
    logic [15:0] total_len;
    logic [15:0] id;
    logic [15:0] flags_frag;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [15:0] checksum;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
  } IPHeader;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } UDPHeader;

endpackage

// File: rtl/udp_tx_arbiter_pkg.sv
// Local types for udp_tx_arbiter: the arbiter FSM state encoding.
package udp_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_GAP
  } arb_state_e;

endpackage

// File: rtl/udp_tx_arbiter_picker.sv
// rr_priority_picker: combinational rotating-priority selector.
// Ports:
//   req   - request vector, one bit per requester
//   last  - index of the most recent winner; search starts at last+1
//   grant - one-hot winner (all zero when no request)
//   valid - at least one request is pending
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic                 valid
);

  localparam int          LW = $clog2(N);
  localparam int unsigned NU = N;

  logic [LW-1:0] idx;

  // Walk offsets 1..N from last, wrapping; the first set bit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NU; k++) begin
      idx = LW'((32'(last) + k) % NU);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin share of one UDP transmitter between
// NUM_REQ payload producers. Latches the winner's payload/addressing,
// raises tx_send for a clean rising edge, follows tx_ready through the
// packet and enforces an idle gap before the next grant.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   req           - request level per requester
//   req_data      - payloads, requester i at [i*8*DATA_WIDTH +: 8*DATA_WIDTH]
//   req_ip_info   - addressing, requester i at element i
//   ack           - one-hot pulse: that requester's payload was latched
//   tx_data       - latched payload to transmitter
//   tx_ip_info    - latched addressing to transmitter
//   tx_send       - send strobe to transmitter
//   tx_ready      - ready from transmitter
//   busy          - arbiter not idle
//   timeout_err   - pulse: transmitter never accepted the send
module udp_tx_arbiter
  import eth_pkg::*;
  import udp_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int GAP_CYCLES     = 16,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*8*DATA_WIDTH-1:0] req_data,
  input  IPInfo [NUM_REQ-1:0]             req_ip_info,
  output logic [NUM_REQ-1:0]              ack,
  output logic [8*DATA_WIDTH-1:0]         tx_data,
  output IPInfo                           tx_ip_info,
  output logic                            tx_send,
  input  logic                            tx_ready,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int LW    = $clog2(NUM_REQ);
  localparam int DW8   = 8 * DATA_WIDTH;
  localparam int ACC_W = $clog2(ACCEPT_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  arb_state_e         state_q, state_d;
  logic [LW-1:0]      last_q, last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DW8-1:0]     tx_data_q, tx_data_d;
  IPInfo              tx_ip_q, tx_ip_d;
  logic               tx_send_q, tx_send_d;
  logic               tout_q, tout_d;

  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [LW-1:0]      win_idx;
  logic [DW8-1:0]     req_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign req_words[g] = req_data[g*DW8 +: DW8];
  end

  rr_priority_picker #(
    .N(NUM_REQ)
  ) u_picker (
    .req  (req),
    .last (last_q),
    .grant(grant),
    .valid(grant_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = LW'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    acc_d     = acc_q;
    gap_d     = gap_q;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    tx_ip_d   = tx_ip_q;
    tx_send_d = tx_send_q;
    tout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid && tx_ready) begin
          tx_data_d = req_words[win_idx];
          tx_ip_d   = req_ip_info[win_idx];
          ack_d     = grant;
          last_d    = win_idx;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_send_d = 1'b1;
        acc_d     = '0;
        state_d   = ST_WAIT_ACCEPT;
      end
      ST_WAIT_ACCEPT: begin
        if (!tx_ready) begin
          tx_send_d = 1'b0;
          state_d   = ST_WAIT_DONE;
        end else if (acc_q == ACC_W'(ACCEPT_TIMEOUT)) begin
          tx_send_d = 1'b0;
          tout_d    = 1'b1;
          gap_d     = GAP_W'(GAP_CYCLES - 1);
          state_d   = ST_GAP;
        end else begin
          acc_d = acc_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          gap_d   = GAP_W'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_q    <= LW'(NUM_REQ - 1);
      acc_q     <= '0;
      gap_q     <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      tx_ip_q   <= '0;
      tx_send_q <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_ip_q   <= tx_ip_d;
      tx_send_q <= tx_send_d;
      tout_q    <= tout_d;
    end
  end

  assign ack         = ack_q;
  assign tx_data     = tx_data_q;
  assign tx_ip_info  = tx_ip_q;
  assign tx_send     = tx_send_q;
  assign busy        = (state_q != ST_IDLE);
  assign timeout_err = tout_q;

endmodule

// File: doc/udp_tx_arbiter.md
# udp_tx_arbiter

Round-robin arbiter that shares one `ethernet_udp_transmit` instance between `NUM_REQ` payload producers. It sits directly upstream of the transmitter. It selects one pending requester, latches that requester's payload and addressing, and generates the rising-edge `send` the transmitter requires. It then tracks the transmitter's `ready` through the whole packet and enforces a minimum idle gap before the next grant.

## Interface
- `NUM_REQ`, default 4: number of requesters; 2..16.
- `DATA_WIDTH`, default 64: payload bytes per packet; must equal the transmitter's `DATA_WIDTH`.
- `GAP_CYCLES`, default 16: minimum `clk` cycles between a packet finishing and the next grant; ≥1.
- `ACCEPT_TIMEOUT`, default 15: cycles to wait for `tx_ready` to fall after `tx_send` rises; ≥2.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `req` in NUM_REQ: request level per requester; payload must be stable while high.
- `req_data` in NUM_REQ*8*DATA_WIDTH: payloads; requester i occupies slice [i*8*DATA_WIDTH +: 8*DATA_WIDTH].
- `req_ip_info` in NUM_REQ×`IPInfo`: addressing; requester i occupies element i.
- `ack` out NUM_REQ: one-hot one-cycle pulse; the payload of that requester has been latched.
- `tx_data` out 8*DATA_WIDTH: latched payload, to transmitter `data`.
- `tx_ip_info` out `IPInfo`: latched addressing, to transmitter `ip_info`.
- `tx_send` out 1: to transmitter `send`.
- `tx_ready` in 1: from transmitter `ready`.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: one-cycle pulse when the transmitter failed to accept.

## Operation
- States: IDLE, SEND, WAIT_ACCEPT, WAIT_DONE, GAP.
- **IDLE:** grant when `|req && tx_ready`. The winner is the first set `req` bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Latch the winner's `req_data` and `req_ip_info` into `tx_data`/`tx_ip_info`.
  - Pulse `ack[winner]`, set `last_grant<=winner`, go to SEND.
- **SEND:** `tx_send<=1`, clear the accept counter, go to WAIT_ACCEPT.
- **WAIT_ACCEPT:**
  - If `tx_ready==0`: `tx_send<=0`, go to WAIT_DONE.
  - Else, when the counter reaches ACCEPT_TIMEOUT: `tx_send<=0`, pulse `timeout_err`, load the gap counter, go to GAP.
  - Otherwise increment the counter.
- **WAIT_DONE:** on `tx_ready==1`, load the gap counter with GAP_CYCLES-1, go to GAP. There is no timeout in this state.
- **GAP:** decrement each cycle; at 0 go to IDLE. `tx_send` is low throughout, which guarantees a fresh rising edge for the next packet.
- **Requester contract:**
  - A requester holding `req` after its `ack` is eligible again, at lowest priority.
  - Dropping `req` before `ack` withdraws the request; nothing is latched.
  - `req` changes outside IDLE are ignored.
- **Simultaneous requests:** resolved purely by the rotating priority, with no fixed bias beyond reset.
- **Latched outputs:** `tx_data`/`tx_ip_info` hold their values until the next grant, so they stay stable for the whole packet.

## Timing
- **Reset values:**
  - Outputs `ack=0`, `tx_send=0`, `tx_data=0`, `tx_ip_info=0`, `busy=0`, `timeout_err=0`.
  - Internal: state IDLE, `last_grant=NUM_REQ-1` so requester 0 wins first.
- **Grant:** from `req` high (IDLE, `tx_ready` high), `ack` and the latched outputs appear at edge N+1 and `tx_send` rises at N+2.
- **Transmitter acceptance:** the transmitter drops `ready` one cycle after seeing the `send` edge. `tx_send` falls the cycle after `ready` is observed low, so it is high for ≥2 cycles.
- **Minimum back-to-back grant spacing:** return of `tx_ready` + GAP_CYCLES + 1.
- **Reset mid-packet:** all outputs return to their reset values on the next edge; any in-flight `ack` is not repeated.

## Structure
- `IPInfo`, `IPHeader` and `UDPHeader` live in a shared package `eth_pkg`. Both this block and the transmitter import them.
- Sub-module `rr_priority_picker #(N)`: purely combinational. Inputs are `req[N]` and `last[$clog2(N)]`; outputs are a one-hot `grant` and a `valid` flag.
- The arbiter holds only the FSM, the counters and the latches.

## Test plan
- **Single requester:** reset, `req=4'b0100`, `tx_ready=1`.
  - → `ack=4'b0100` one cycle; `tx_data` equals slice 2; `tx_send` rises the following cycle.
- **Fairness:** all four `req` held high, transmitter model completing each packet in 10 cycles.
  - → grant order 0,1,2,3,0.
  - → consecutive `ack` pulses separated by ≥ 10+GAP_CYCLES+1 cycles.
- **Transmitter never accepts:** `tx_ready` stuck high.
  - → `timeout_err` pulses exactly ACCEPT_TIMEOUT+2 cycles after the grant.
  - → `tx_send` low afterward; re-arbitration happens after GAP.
- **Not ready:** `tx_ready=0` in IDLE with `req=1`.
  - → no `ack` until `tx_ready` rises; then the grant proceeds normally.
- **Reset mid-packet:** `reset` asserted during WAIT_DONE.
  - → next cycle `tx_send=0`, `busy=0`.
  - → first grant after reset goes to the lowest-index active requester.
- **Late request:** `req[1]` raised during GAP only.
  - → ignored until IDLE, then granted with one-cycle latency.
